// File: rtl/jtag_wb_pkg.sv
// Shared constants for the JTAG user-DR to Wishbone bridge: command codes,
// FSM states, DR field offsets and the jtag bundle bit positions.
package jtag_wb_pkg;

    localparam logic [1:0] CMD_NOP = 2'b00;
    localparam logic [1:0] CMD_WR  = 2'b01;
    localparam logic [1:0] CMD_RD  = 2'b10;
    localparam logic [1:0] CMD_CLR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUS,
        ST_DONE
    } wb_state_t;

    // DR layout: [1:0] cmd, then address, then data
    localparam int unsigned CMD_LSB = 0;
    localparam int unsigned ADR_LSB = 2;

    function automatic int unsigned dat_lsb(input int unsigned aw);
        return ADR_LSB + aw;
    endfunction

    // Bit positions inside the 6-bit jtag bundle fed to jtag_edge_sync
    localparam int unsigned J_TCK   = 0;
    localparam int unsigned J_TDI   = 1;
    localparam int unsigned J_SEL   = 2;
    localparam int unsigned J_CAP   = 3;
    localparam int unsigned J_SHIFT = 4;
    localparam int unsigned J_UPD   = 5;

endpackage

// File: rtl/jtag_wb_edge_sync.sv
// 2-FF synchronizer and TCK edge detector for the 6-bit jtag bundle.
module jtag_edge_sync
    import jtag_wb_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] i_jtag,
    output logic       o_tck_rise,
    output logic       o_tck_fall,
    output logic [4:0] o_ctl
);

    logic [5:0] r_s1;
    logic [5:0] r_s2;
    logic [5:0] r_s3;
    logic       r_rise;
    logic       r_fall;

    // r_s3 is the edge register; controls are taken from it so they line up
    // with the registered rise/fall pulses (3 clk after the physical edge).
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1   <= '0;
            r_s2   <= '0;
            r_s3   <= '0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_s1   <= i_jtag;
            r_s2   <= r_s1;
            r_s3   <= r_s2;
            r_rise <= r_s2[J_TCK] & ~r_s3[J_TCK];
            r_fall <= ~r_s2[J_TCK] & r_s3[J_TCK];
        end
    end

    assign o_tck_rise = r_rise;
    assign o_tck_fall = r_fall;
    assign o_ctl      = r_s3[5:1];

endmodule

// File: rtl/jtag_dr_wb_bridge.sv
// JTAG user data register bridged to a single-transaction Wishbone master.
// Optional bus watchdog: define JTAG_WB_TIMEOUT_EN.
module jtag_dr_wb_bridge
    import jtag_wb_pkg::*;
#(
    parameter int unsigned AW          = 32,
    parameter int unsigned DW          = 32,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            jtag_tck,
    input  logic            jtag_tdi,
    input  logic            jtag_sel,
    input  logic            jtag_capture,
    input  logic            jtag_shift,
    input  logic            jtag_update,
    output logic            jtag_tdo,
    output logic [AW-1:0]   m_adr_o,
    output logic [DW-1:0]   m_dat_o,
    input  logic [DW-1:0]   m_dat_i,
    output logic [DW/8-1:0] m_sel_o,
    output logic            m_we_o,
    output logic            m_cyc_o,
    output logic            m_stb_o,
    input  logic            m_ack_i,
    input  logic            m_err_i
);

    localparam int unsigned DRW     = 2 + AW + DW;
    localparam int unsigned DAT_LSB = dat_lsb(AW);

    if ((DW % 8) != 0 || TIMEOUT_CYC == 0) begin : g_cfg_err
        $error("jtag_dr_wb_bridge: DW must be a multiple of 8 and TIMEOUT_CYC nonzero");
    end

    logic [5:0] w_jtag;
    logic [4:0] w_ctl;
    logic       w_rise;
    logic       w_fall;
    logic       w_tdi;
    logic       w_sel;
    logic       w_cap;
    logic       w_shift;
    logic       w_upd;

    assign w_jtag = {jtag_update, jtag_shift, jtag_capture, jtag_sel, jtag_tdi, jtag_tck};

    jtag_edge_sync u_sync (
        .clk        (clk),
        .reset      (reset),
        .i_jtag     (w_jtag),
        .o_tck_rise (w_rise),
        .o_tck_fall (w_fall),
        .o_ctl      (w_ctl)
    );

    assign w_tdi   = w_ctl[J_TDI-1];
    assign w_sel   = w_ctl[J_SEL-1];
    assign w_cap   = w_ctl[J_CAP-1];
    assign w_shift = w_ctl[J_SHIFT-1];
    assign w_upd   = w_ctl[J_UPD-1];

    wb_state_t       r_state;
    wb_state_t       w_state_nx;
    logic [DRW-1:0]  r_dr;
    logic            r_tdo;
    logic [1:0]      r_cmd_q;
    logic [AW-1:0]   r_adr_q;
    logic [DW-1:0]   r_wdat_q;
    logic            r_upd_req;
    logic [AW-1:0]   r_adr;
    logic [DW-1:0]   r_dat;
    logic            r_we;
    logic [DW-1:0]   r_rd_data_q;
    logic [AW-1:0]   r_last_adr_q;
    logic            r_err_q;
    logic            r_ovr_q;
    logic            w_busy;
    logic            w_start;
    logic            w_clr;
    logic            w_ovr;
    logic            w_end;
    logic            w_bus_err;
    logic            w_tmo;

    assign w_busy = (r_state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_dr      <= '0;
            r_tdo     <= 1'b0;
            r_cmd_q   <= CMD_NOP;
            r_adr_q   <= '0;
            r_wdat_q  <= '0;
            r_upd_req <= 1'b0;
        end else begin
            r_upd_req <= 1'b0;
            if (w_rise && w_sel) begin
                if (w_cap) begin
                    r_dr <= {r_rd_data_q, r_last_adr_q, r_err_q | r_ovr_q, w_busy};
                end else if (w_shift) begin
                    r_dr <= {w_tdi, r_dr[DRW-1:1]};
                end else if (w_upd) begin
                    r_cmd_q   <= r_dr[CMD_LSB +: 2];
                    r_adr_q   <= r_dr[ADR_LSB +: AW];
                    r_wdat_q  <= r_dr[DAT_LSB +: DW];
                    r_upd_req <= 1'b1;
                end
            end
            if (w_fall) begin
                r_tdo <= r_dr[0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_start    = 1'b0;
        w_clr      = 1'b0;
        w_end      = 1'b0;
        w_bus_err  = 1'b0;
        w_ovr      = r_upd_req && (r_state != ST_IDLE);
        case (r_state)
            ST_IDLE: begin
                if (r_upd_req) begin
                    if (r_cmd_q == CMD_WR || r_cmd_q == CMD_RD) begin
                        w_start    = 1'b1;
                        w_state_nx = ST_BUS;
                    end else if (r_cmd_q == CMD_CLR) begin
                        w_clr = 1'b1;
                    end
                end
            end
            ST_BUS: begin
                if (m_ack_i || m_err_i || w_tmo) begin
                    w_end      = 1'b1;
                    // err beats a simultaneous ack; no ack and no err means watchdog
                    w_bus_err  = m_err_i || !m_ack_i;
                    w_state_nx = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nx = ST_IDLE;
            end
            default: begin
                w_state_nx = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_adr        <= '0;
            r_dat        <= '0;
            r_we         <= 1'b0;
            r_rd_data_q  <= '0;
            r_last_adr_q <= '0;
            r_err_q      <= 1'b0;
            r_ovr_q      <= 1'b0;
        end else begin
            if (w_start) begin
                r_adr <= r_adr_q;
                r_dat <= r_wdat_q;
                r_we  <= (r_cmd_q == CMD_WR);
            end
            // r_adr rather than r_adr_q: an overrun update may already have rewritten r_adr_q
            if (w_end) begin
                r_we         <= 1'b0;
                r_last_adr_q <= r_adr;
                if (w_bus_err) begin
                    r_err_q <= 1'b1;
                end else if (!r_we) begin
                    r_rd_data_q <= m_dat_i;
                end
            end
            if (w_clr) begin
                r_err_q <= 1'b0;
                r_ovr_q <= 1'b0;
            end
            if (w_ovr) begin
                r_ovr_q <= 1'b1;
            end
        end
    end

`ifdef JTAG_WB_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TMO_W-1:0] r_tmo_cnt;

    always_ff @(posedge clk) begin
        if (reset || w_start) begin
            r_tmo_cnt <= '0;
        end else if (r_state == ST_BUS) begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
    end

    assign w_tmo = (r_state == ST_BUS) && (r_tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));
`else
    assign w_tmo = 1'b0;
`endif

    assign jtag_tdo = r_tdo;
    assign m_adr_o  = r_adr;
    assign m_dat_o  = r_dat;
    assign m_we_o   = r_we;
    assign m_sel_o  = '1;
    assign m_cyc_o  = (r_state == ST_BUS);
    assign m_stb_o  = (r_state == ST_BUS);

endmodule
